// File: rtl/option_dispatcher_if.sv
// Packet stream and engine-bank handshake bundle for option_dispatcher.
// Upstream: a packet transfers on a rising clock edge where in_valid and in_ready are both high; bs_start and bs_done are single-cycle pulses.
interface option_dispatcher_if #(
  parameter int NUM_MODS = 4,
  parameter int PKT_W    = 192
);
  logic                in_valid;
  logic                in_ready;
  logic [PKT_W-1:0]    in_pkt;
  logic                stream_done;
  logic [NUM_MODS-1:0] bs_start;
  logic [PKT_W-1:0]    bs_pkt;
  logic [NUM_MODS-1:0] bs_done;

  modport master (
    output in_valid, in_pkt, stream_done, bs_done,
    input  in_ready, bs_start, bs_pkt
  );

  modport slave (
    input  in_valid, in_pkt, stream_done, bs_done,
    output in_ready, bs_start, bs_pkt
  );
endinterface

// File: rtl/option_dispatcher.sv
// Buffers option packets and issues each to the next idle Black-Scholes engine, round-robin.
// Optional statistics counters are enabled by defining DISPATCH_STATS_EN.
module option_dispatcher #(
  parameter int NUM_MODS = 4,
  parameter int PKT_W    = 192,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  option_dispatcher_if.slave         bus,
  output logic [NUM_MODS-1:0]        busy,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       all_done,
  output logic [CNT_W-1:0]           dispatch_cnt,
  output logic [CNT_W-1:0]           stall_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = (NUM_MODS > 1) ? $clog2(NUM_MODS) : 1;

  logic [PKT_W-1:0]    mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic [RW-1:0]       rr_ptr;
  logic [NUM_MODS-1:0] start_q;
  logic [PKT_W-1:0]    pkt_q;

  logic                push;
  logic                dispatch;
  logic                found;
  logic [RW-1:0]       grant_idx;
  logic [NUM_MODS-1:0] grant_oh;

  assign bus.in_ready = (count < CW'(DEPTH));
  assign bus.bs_start = start_q;
  assign bus.bs_pkt   = pkt_q;
  assign fifo_count   = count;

  assign push     = bus.in_valid & bus.in_ready;
  assign dispatch = (count != '0) & found;

  // First idle engine at or after rr_ptr, searching with wrap-around.
  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_MODS; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_MODS;
      if (!found && !busy[idx]) begin
        found     = 1'b1;
        grant_idx = RW'(idx);
      end
    end
  end

  assign grant_oh = NUM_MODS'(1) << grant_idx;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.in_pkt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rr_ptr   <= '0;
      start_q  <= '0;
      pkt_q    <= '0;
      busy     <= '0;
      all_done <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (dispatch) rd_ptr <= rd_ptr + AW'(1);
      case ({push, dispatch})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      start_q <= dispatch ? grant_oh : '0;
      if (dispatch) begin
        pkt_q  <= mem[rd_ptr];
        rr_ptr <= (int'(grant_idx) == NUM_MODS - 1) ? '0 : grant_idx + RW'(1);
      end
      // Done pulses for idle engines fall out of the AND with busy.
      busy     <= (busy & ~bus.bs_done) | (dispatch ? grant_oh : '0);
      all_done <= bus.stream_done && (count == '0) && (busy == '0) && (start_q == '0);
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [CNT_W-1:0] disp_q;
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp_q  <= '0;
      stall_q <= '0;
    end else begin
      if (dispatch && (disp_q != '1)) disp_q <= disp_q + CNT_W'(1);
      if ((count != '0) && (&busy) && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign dispatch_cnt = disp_q;
  assign stall_cnt    = stall_q;
`else
  assign dispatch_cnt = '0;
  assign stall_cnt    = '0;
`endif
endmodule

// File: tb/tb_option_dispatcher.sv
// Directed bench for option_dispatcher: NUM_MODS=4, DEPTH=4, hand-computed expectations per edge.
module tb_option_dispatcher;
  localparam int NM    = 4;
  localparam int PW    = 192;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clock;
  logic             reset;
  logic [NM-1:0]    busy;
  logic [2:0]       fifo_count;
  logic             all_done;
  logic [CNT_W-1:0] dispatch_cnt;
  logic [CNT_W-1:0] stall_cnt;

  int total;
  int bad;

  option_dispatcher_if #(.NUM_MODS(NM), .PKT_W(PW)) bus ();

  option_dispatcher #(.NUM_MODS(NM), .PKT_W(PW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .all_done     (all_done),
    .dispatch_cnt (dispatch_cnt),
    .stall_cnt    (stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [PW-1:0] pkt(input int n);
    return {32'(n), 32'(n + 100), 32'(n + 200), 32'(n * 3), 32'(n * 7 + 1), 32'hbeef0000 | 32'(n)};
  endfunction

  function automatic int stat(input int n);
`ifdef DISPATCH_STATS_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [NM-1:0] st, input int id,
                          input logic [NM-1:0] bz, input int cnt);
    chk({tag, ".start"}, 256'(bus.bs_start), 256'(st));
    if (id > 0) chk({tag, ".pkt"}, 256'(bus.bs_pkt), 256'(pkt(id)));
    chk({tag, ".busy"}, 256'(busy), 256'(bz));
    chk({tag, ".count"}, 256'(fifo_count), 256'(cnt));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".in_ready"}, 256'(bus.in_ready), 256'(1));
    chk({tag, ".start"}, 256'(bus.bs_start), 256'(0));
    chk({tag, ".pkt"}, 256'(bus.bs_pkt), 256'(0));
    chk({tag, ".busy"}, 256'(busy), 256'(0));
    chk({tag, ".count"}, 256'(fifo_count), 256'(0));
    chk({tag, ".all_done"}, 256'(all_done), 256'(0));
    chk({tag, ".disp_cnt"}, 256'(dispatch_cnt), 256'(0));
    chk({tag, ".stall_cnt"}, 256'(stall_cnt), 256'(0));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_pkt      = '0;
    bus.stream_done = 1'b0;
    bus.bs_done     = '0;
    step();
    step();
    chk_reset_vals("rst");
    reset = 1'b1;
    step();

    // Six packets back-to-back, engines never finish.
    bus.in_valid = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      bus.in_pkt = pkt(n);
      step();
      if (n >= 2 && n <= 5)
        chk_disp($sformatf("b2b%0d", n), NM'(1) << (n - 2), n - 1, NM'((1 << (n - 1)) - 1), 1);
    end
    bus.in_valid = 1'b0;
    chk_disp("b2b6", 4'b0000, 4, 4'b1111, 2);
    chk("b2b6.in_ready", 256'(bus.in_ready), 256'(1));
    step();
    chk("idle.stall", 256'(stall_cnt), 256'(stat(2)));
    chk("idle.disp", 256'(dispatch_cnt), 256'(stat(4)));

    // Engine 2 completes; it gets packet 5 on the following edge.
    bus.bs_done = 4'b0100;
    step();
    bus.bs_done = '0;
    chk_disp("done2", 4'b0000, 0, 4'b1011, 2);
    step();
    chk_disp("redisp2", 4'b0100, 5, 4'b1111, 1);

    // Fill to DEPTH with every engine busy.
    bus.in_valid = 1'b1;
    for (int n = 7; n <= 9; n++) begin
      bus.in_pkt = pkt(n);
      step();
    end
    chk("full.count", 256'(fifo_count), 256'(4));
    chk("full.in_ready", 256'(bus.in_ready), 256'(0));
    bus.in_pkt = pkt(10);
    step();
    chk("full_hold.count", 256'(fifo_count), 256'(4));
    // Free engines 0 and 3 together: rr_ptr=3 must pick engine 3 first.
    bus.bs_done = 4'b1001;
    step();
    bus.bs_done = '0;
    chk_disp("free03", 4'b0000, 0, 4'b0110, 4);
    step();
    chk_disp("rr3", 4'b1000, 6, 4'b1110, 3);
    chk("rr3.in_ready", 256'(bus.in_ready), 256'(1));
    step();
    bus.in_valid = 1'b0;
    chk_disp("rr0", 4'b0001, 7, 4'b1111, 3);
    chk("mid.disp", 256'(dispatch_cnt), 256'(stat(7)));
    chk("mid.stall", 256'(stall_cnt), 256'(stat(8)));

    // Drain with upstream finished.
    bus.stream_done = 1'b1;
    bus.bs_done = 4'b1111;
    step();
    bus.bs_done = '0;
    chk_disp("all_free", 4'b0000, 0, 4'b0000, 3);
    step();
    chk_disp("drain8", 4'b0010, 8, 4'b0010, 2);
    step();
    chk_disp("drain9", 4'b0100, 9, 4'b0110, 1);
    step();
    chk_disp("drain10", 4'b1000, 10, 4'b1110, 0);
    bus.bs_done = 4'b0010;
    step();
    chk("done1.busy", 256'(busy), 256'(4'b1100));
    // Done pulses on idle engines 0 and 1 must change nothing.
    bus.bs_done = 4'b0011;
    step();
    chk("done_idle.busy", 256'(busy), 256'(4'b1100));
    chk("done_idle.start", 256'(bus.bs_start), 256'(0));
    chk("done_idle.disp", 256'(dispatch_cnt), 256'(stat(10)));
    bus.bs_done = 4'b1000;
    step();
    bus.bs_done = 4'b0100;
    step();
    bus.bs_done = '0;
    chk("last_done.busy", 256'(busy), 256'(0));
    chk("last_done.all_done", 256'(all_done), 256'(0));
    step();
    chk("all_done.set", 256'(all_done), 256'(1));
    bus.in_valid = 1'b1;
    bus.in_pkt   = pkt(11);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("all_done.drop", 256'(all_done), 256'(0));
    chk_disp("late11", 4'b0001, 11, 4'b0001, 0);

    // Build 3 buffered / 2 busy, then reset asynchronously.
    bus.stream_done = 1'b0;
    bus.in_valid = 1'b1;
    for (int n = 12; n <= 17; n++) begin
      bus.in_pkt = pkt(n);
      step();
    end
    bus.in_valid = 1'b0;
    chk_disp("pre_rst", 4'b0000, 14, 4'b1111, 3);
    bus.bs_done = 4'b0101;
    step();
    bus.bs_done = '0;
    chk_disp("pre_rst2", 4'b0000, 14, 4'b1010, 3);
    chk("pre_rst.disp", 256'(dispatch_cnt), 256'(stat(14)));
    chk("pre_rst.stall", 256'(stall_cnt), 256'(stat(12)));
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    #2;
    reset = 1'b1;
    step();
    bus.bs_done = 4'b1010;
    step();
    bus.bs_done = '0;
    chk("stale_done.busy", 256'(busy), 256'(0));
    bus.in_valid = 1'b1;
    bus.in_pkt   = pkt(20);
    step();
    bus.in_valid = 1'b0;
    chk_disp("post_push", 4'b0000, 0, 4'b0000, 1);
    step();
    chk_disp("post_rst", 4'b0001, 20, 4'b0001, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
